// File: rtl/brom_arbiter_if.sv
// brom_arbiter_if: request/response handshakes and the block ROM port of brom_arbiter.
// slave is the arbiter side; master is the requesters plus the ROM.
interface brom_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic              rsp0_valid, rsp1_valid;
    logic              rsp0_ready, rsp1_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    modport slave (
        input  req0_valid, req1_valid, req0_addr, req1_addr, rsp0_ready, rsp1_ready, rom_data,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rom_addr
    );
    modport master (
        output req0_valid, req1_valid, req0_addr, req1_addr, rsp0_ready, rsp1_ready, rom_data,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rom_addr
    );
endinterface

// File: rtl/brom_arbiter.sv
// brom_arbiter: two requesters share one registered block ROM, one read in flight at a time.
// Define BROM_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module brom_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input logic           clock,
    input logic           reset,
    brom_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, CAPT, RESP} state_t;
    state_t            state;
    logic              owner, gnt1, accept, rsp0_q, rsp1_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [DATA_W-1:0] rsp_data_q;
`ifdef BROM_ARB_RR_EN
    logic prio;  // high: requester 1 wins the next tie
    assign gnt1 = bus.req1_valid && (!bus.req0_valid || prio);
`else
    assign gnt1 = bus.req1_valid && !bus.req0_valid;
`endif
    assign bus.req0_ready = state == IDLE && !reset && bus.req0_valid && !gnt1;
    assign bus.req1_ready = state == IDLE && !reset && gnt1;
    assign accept         = bus.req0_ready || bus.req1_ready;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            rom_addr_q <= '0;
            rsp_data_q <= '0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
`ifdef BROM_ARB_RR_EN
            prio       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rom_addr_q <= gnt1 ? bus.req1_addr : bus.req0_addr;
                    owner      <= gnt1;
                    state      <= READ;
`ifdef BROM_ARB_RR_EN
                    prio       <= !gnt1;
`endif
                end
                READ: state <= CAPT;
                CAPT: begin
                    rsp_data_q <= bus.rom_data;
                    rsp0_q     <= !owner;
                    rsp1_q     <= owner;
                    state      <= RESP;
                end
                RESP: if (owner ? bus.rsp1_ready : bus.rsp0_ready) begin
                    rsp0_q <= 1'b0;
                    rsp1_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_brom_arbiter.sv
// tb_brom_arbiter: directed table, hand-written corner sequences and a random run against
// a latency-counting transaction model of the arbiter.
module tb_brom_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
`ifdef BROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    brom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    brom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    logic [DW-1:0] mem [256];
    always_ff @(posedge clock) bus.rom_data <= mem[bus.rom_addr];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       v0;
        logic [7:0] a0;
        logic       v1;
        logic [7:0] a1;
        logic       r0;
        logic       r1;
        logic [1:0] rdy;
        logic [1:0] rv;
        logic [7:0] data;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [7:0] a0, input logic v1, input logic [7:0] a1,
                         input logic r0, input logic r1);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.rsp0_ready = r0;
        bus.rsp1_ready = r1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [11:0] obs();
        logic [1:0] rv;
        rv = {bus.rsp1_valid, bus.rsp0_valid};
        return {bus.req1_ready, bus.req0_ready, rv, (rv != 0) ? bus.rsp_data : 8'h00};
    endfunction

    // transaction model state
    logic       busy, own, last, p0, p1;
    int         lat;
    logic [7:0] ea;
    logic       gq [$];
    logic [7:0] dq [$];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'hA1;
        mem[8'h01] = 8'hB2;
        mem[8'h02] = 8'hC3;
        mem[8'h55] = 8'h5A;
        mem[8'hFF] = 8'h00;

        tbl[0]  = '{1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 2'b00, 8'h00};
        tbl[1]  = '{1'b0, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00};
        tbl[2]  = '{1'b0, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00};
        tbl[3]  = '{1'b0, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b01, 8'hC3};
        tbl[4]  = '{1'b0, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 2'b01, 8'hC3};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1, 2'b10, 2'b00, 8'h00};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1, 2'b00, 2'b00, 8'h00};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1, 2'b00, 2'b00, 8'h00};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1, 2'b00, 2'b10, 8'h00};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1, 2'b10, 2'b00, 8'h00};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b00, 8'h00};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b00, 8'h00};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b10, 8'h00};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00};

        // reset state, with both requesters asking
        drive(1, 8'h12, 1, 8'h34, 1, 1);
        #12;
        chk("reset_outputs", {obs(), bus.rsp_data, bus.rom_addr}, 28'h0);
        @(negedge clock);
        reset = 1'b0;

        // single read, spurious inputs, 0xFF boundary and 4-cycle back-to-back
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v0, tbl[i].a0, tbl[i].v1, tbl[i].a1, tbl[i].r0, tbl[i].r1);
            #1;
            chk($sformatf("table_row%0d", i), obs(), {tbl[i].rdy, tbl[i].rv, tbl[i].data});
            @(negedge clock);
        end

        // backpressure on requester 1 while requester 0 waits
        drive(0, 8'h00, 1, 8'h01, 0, 0);
        #1 chk("bp_accept", obs(), 12'h800);
        @(negedge clock);
        drive(1, 8'h00, 0, 8'h00, 0, 0);
        cycles(2);
        for (int k = 0; k < 5; k++) begin
            #1 chk($sformatf("bp_hold%0d", k), obs(), 12'h2B2);
            @(negedge clock);
        end
        bus.rsp1_ready = 1'b1;
        #1 chk("bp_release", obs(), 12'h2B2);
        @(negedge clock);
        bus.rsp1_ready = 1'b0;
        #1 chk("bp_idle_after", obs(), 12'h400);
        @(negedge clock);
        drive(0, 8'h00, 0, 8'h00, 1, 0);
        cycles(2);
        #1 chk("bp_req0_rsp", obs(), 12'h1A1);
        cycles(1);

        // contention from a fresh reset
        pulse_reset();
        drive(1, 8'h00, 1, 8'h01, 1, 1);
        for (int k = 0; k < 40 && (gq.size() < 4 || dq.size() < 4); k++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) gq.push_back(bus.req1_ready);
            if (bus.rsp0_valid || bus.rsp1_valid) dq.push_back(bus.rsp_data);
            @(negedge clock);
        end
        chk("cont_count", {gq.size() >= 4, dq.size() >= 4}, 2'b11);
        for (int k = 0; k < 4 && k < gq.size() && k < dq.size(); k++) begin
            chk($sformatf("cont_grant%0d", k), gq[k], RR ? k % 2 : 0);
            chk($sformatf("cont_data%0d", k), dq[k], (RR && k % 2 == 1) ? 8'hB2 : 8'hA1);
        end
        drive(0, 0, 0, 0, 1, 1);
        cycles(5);

        // reset pulsed while a read is in flight
        drive(1, 8'h02, 0, 8'h00, 1, 0);
        #1 chk("rst_accept", obs(), 12'h400);
        @(negedge clock);
        drive(0, 8'h00, 0, 8'h00, 1, 0);
        #1 reset = 1'b1;
        #1 chk("rst_mid_outputs", {obs(), bus.rsp_data, bus.rom_addr}, 28'h0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("rst_no_rsp%0d", k), obs(), 12'h0);
            @(negedge clock);
        end
        drive(1, 8'h02, 0, 8'h00, 1, 0);
        #1 chk("rst_reissue", obs(), 12'h400);
        @(negedge clock);
        drive(0, 8'h00, 0, 8'h00, 1, 0);
        cycles(2);
        #1 chk("rst_reissue_rsp", obs(), 12'h1C3);
        cycles(2);

        // random traffic against the transaction model
        pulse_reset();
        busy = 0; own = 0; last = 1; p0 = 0; p1 = 0; lat = 0; ea = 0;
        for (int n = 0; n < 3000; n++) begin
            logic       g1, er0, er1, rr0, rr1;
            logic [7:0] a0, a1;
            #1 chk("rand_rsp", {bus.rsp1_valid, bus.rsp0_valid, (bus.rsp0_valid || bus.rsp1_valid) ? bus.rsp_data : 8'h00},
                   {busy && lat == 2 && own, busy && lat == 2 && !own, (busy && lat == 2) ? mem[ea] : 8'h00});
            if (!p0) p0 = ($urandom_range(2) == 0);
            if (!p1) p1 = ($urandom_range(2) == 0);
            a0  = 8'($urandom);
            a1  = 8'($urandom);
            rr0 = 1'($urandom);
            rr1 = 1'($urandom);
            drive(p0, a0, p1, a1, rr0, rr1);
            #1;
            g1  = p1 && (!p0 || (RR && last == 0));
            er0 = !busy && p0 && !g1;
            er1 = !busy && g1;
            chk("rand_ready", {bus.req1_ready, bus.req0_ready}, {er1, er0});
            if (er0 || er1) begin
                busy = 1; lat = 0; own = er1; last = er1;
                ea = er1 ? a1 : a0;
                if (er0) p0 = 0;
                if (er1) p1 = 0;
            end else if (busy && lat == 2 && (own ? rr1 : rr0)) busy = 0;
            else if (busy && lat < 2) lat++;
            @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/brom_arbiter.md
BROM_ARBITER -- requirements
Module: brom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, address width of the shared block ROM.
REQ-002 Parameter DATA_W, default 8, data width of the shared block ROM.
REQ-003 The block SHALL use one clock and an asynchronous active-high reset, exposed as the two ports below.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req0_valid / req1_valid  input  1 each  requester N has a read address pending.
REQ-007 req0_addr / req1_addr  input  ADDR_W each  read address for requester N.
REQ-008 req0_ready / req1_ready  output  1 each  request N accepted on this edge when valid and ready are both high.
REQ-009 rsp0_valid / rsp1_valid  output  1 each  response data for requester N is held on rsp_data.
REQ-010 rsp0_ready / rsp1_ready  input  1 each  requester N consumes the response.
REQ-011 rsp_data  output  DATA_W  shared response data; meaningful only while an rspN_valid is high.
REQ-012 rom_addr  output  ADDR_W  registered address to the block ROM.
REQ-013 rom_data  input  DATA_W  ROM registered output; valid one clock after rom_addr changes.

Function
REQ-014 The block SHALL have a state machine with states IDLE, READ, CAPT and RESP, and exactly one request outstanding at any time.
REQ-015 IDLE: the block SHALL assert reqN_ready only for the granted requester, and only while reqN_valid is high.
- On the accept edge it SHALL register reqN_addr into rom_addr, record the owner, and go to READ.
- With no request valid it SHALL stay in IDLE, with rom_addr unchanged.
REQ-016 READ: the block SHALL hold rom_addr for one cycle while the ROM registers the address, then go to CAPT.
REQ-017 CAPT: the block SHALL capture rom_data into rsp_data, set rsp<owner>_valid, and go to RESP.
REQ-018 RESP: the block SHALL hold rsp_data and rsp<owner>_valid stable until rsp<owner>_ready is high on an edge, then clear valid and return to IDLE.
REQ-019 Latency: rsp valid SHALL rise on the 2nd rising edge after the accept edge.
- With rsp_ready held high, the minimum request-to-request spacing SHALL be 4 cycles.
REQ-020 reqN_ready SHALL be low in READ, CAPT and RESP; requests arriving then SHALL wait, and no request SHALL be dropped or duplicated.
REQ-021 rspN_valid SHALL never be high for both requesters at once, and never for the non-owner.
REQ-022 rspN_ready while rspN_valid is low SHALL be ignored.
REQ-023 reqN_addr changes while reqN_ready is low SHALL have no effect.
REQ-024 Addresses SHALL wrap naturally at the ADDR_W width; no address range checking.
REQ-025 Arbitration policy SHALL be set by REQ-030/REQ-031; a lone valid requester SHALL always be granted.

Reset
REQ-026 On reset the state SHALL be IDLE, rom_addr and rsp_data 0, rsp0_valid and rsp1_valid 0, and the round-robin pointer pointing to requester 0.
REQ-027 Reset asserted mid-transaction SHALL abort it immediately; no response for it SHALL be issued after reset releases.
REQ-028 req0_ready/req1_ready SHALL be low while reset is high.

Configuration
REQ-029 Macro BROM_ARB_RR_EN SHALL select the arbitration policy.
REQ-030 With BROM_ARB_RR_EN defined: round-robin.
- When both requesters are valid in IDLE, the requester not served last SHALL be granted.
- The pointer SHALL update only on an accept edge.
REQ-031 With BROM_ARB_RR_EN undefined: fixed priority, requester 0 always wins a simultaneous request, and no pointer register SHALL exist.

Verification
REQ-032 Single read: ROM holds 0xC3 at address 2; req0 addr=2 accepted at edge E0 -> rsp0_valid=1, rsp_data=0xC3 after E0+2; rsp1_valid stays 0.
REQ-033 Backpressure: rsp1_ready held low 5 cycles after rsp1_valid rises -> rsp_data/rsp1_valid stable, req0_ready=0 throughout, then IDLE one edge after rsp1_ready rises.
REQ-034 Contention, BROM_ARB_RR_EN defined: both valid continuously, addrs 0 and 1 (0xA1, 0xB2) -> grants alternate 0,1,0,1 and responses alternate 0xA1, 0xB2.
- Same stimulus, macro undefined -> requester 0 granted every time, responses all 0xA1.
REQ-035 Reset mid-operation: reset pulsed in READ -> all outputs 0 and no rsp valid after release; req re-issued -> normal response.
REQ-036 Boundary: addr=0xFF (ROM default 0x00) with rsp_ready high -> rsp_data=0x00; back-to-back accepts exactly 4 cycles apart.
REQ-037 Spurious inputs: rsp0_ready pulsed in IDLE and req0_addr changed during READ -> no state change, and the response carries the accepted address's data.
